uart_echo_buffer: RTL and testbench

- Parametrised byte-stream buffer between the UART receive AXI-stream output and the UART transmit AXI-stream input.
- Generalises single-register echo to a DEPTH-entry FIFO with a registered output stage, selectable run-time modes, an overflow policy and status counters.
- Sits in fpga_core-level logic, clocked with the UART.

---
 rtl/uart_echo_pkg.sv | 30 +++
 rtl/uart_echo_buffer_sync_fifo_ram.sv | 26 ++
 rtl/uart_echo_buffer.sv | 150 +++++++++++++++
 tb/tb_uart_echo_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared encodings and helpers for the UART echo buffer.
// Holds the run-time mode encoding, the ASCII case bounds and the case-swap helper.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO  = 2'b00,
        MODE_SWAP  = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_FLUSH = 2'b11
    } mode_e;

    localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
    localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
    localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;
    localparam logic [7:0] CASE_DELTA     = 8'h20;

    // Swap letter case; non-letters pass through unchanged.
    function automatic logic [7:0] swap_case(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b >= ASCII_UPPER_LO && b <= ASCII_UPPER_HI) begin
            r = b + CASE_DELTA;
        end else if (b >= ASCII_LOWER_LO && b <= ASCII_LOWER_HI) begin
            r = b - CASE_DELTA;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_echo_buffer_sync_fifo_ram.sv
// FIFO storage: DEPTH x DATA_WIDTH array, synchronous write, combinational head read.
// Pointers, occupancy and output staging live in the parent.
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_echo_buffer.sv
// Byte-stream buffer between UART rx and tx AXI-streams: FIFO plus registered output stage,
// run-time echo/case-swap/hold/flush modes, optional drop-on-full and status counters.
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DROP_ON_FULL = 0,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    input  logic [1:0]                   mode,
    input  logic                         clear_status,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    output logic [COUNT_WIDTH-1:0]       rx_count,
    output logic [COUNT_WIDTH-1:0]       tx_count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    mode_e                  mode_s;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       occupancy;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0] rx_count_q, rx_count_d;
    logic [COUNT_WIDTH-1:0] tx_count_q, tx_count_d;
    logic [DATA_WIDTH-1:0]  head;
    logic [DATA_WIDTH-1:0]  head_swap;
    logic                   full, empty;
    logic                   in_hs, out_hs, push, drop, pop;

    assign mode_s    = mode_e'(mode);
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (occupancy == PTR_W'(DEPTH));
    assign empty     = (occupancy == '0);

    // Ready is combinational so a drained FIFO can accept in the same cycle.
    assign s_axis_tready = !rst_n || (DROP_ON_FULL != 0) || !full || (mode_s == MODE_FLUSH);

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (s_axis_tdata),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (head)
    );

    // Case swap only makes sense for byte-wide streams; wider words pass through.
    if (DATA_WIDTH == 8) begin : g_swap
        assign head_swap = swap_case(head);
    end else begin : g_no_swap
        assign head_swap = head;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        overflow_d = overflow_q;
        rx_count_d = rx_count_q;
        tx_count_d = tx_count_q;

        in_hs  = s_axis_tvalid && s_axis_tready;
        out_hs = tvalid_q && m_axis_tready;
        // Full is taken from the pre-edge occupancy: no write-through at full.
        push   = in_hs && (mode_s != MODE_FLUSH) && !full;
        drop   = in_hs && (mode_s != MODE_FLUSH) && full;
        pop    = (!tvalid_q || m_axis_tready) && !empty
                 && ((mode_s == MODE_ECHO) || (mode_s == MODE_SWAP));

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            rx_count_d = rx_count_q + COUNT_WIDTH'(1);
        end

        if (mode_s == MODE_FLUSH) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            tdata_d  = (mode_s == MODE_SWAP) ? head_swap : head;
            tvalid_d = 1'b1;
        end else if (out_hs) begin
            tvalid_d = 1'b0;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end
        if (out_hs) begin
            tx_count_d = tx_count_q + COUNT_WIDTH'(1);
        end

        // Clear has priority over any same-cycle set or increment.
        if (clear_status) begin
            overflow_d = 1'b0;
            rx_count_d = '0;
            tx_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            overflow_q <= overflow_d;
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign fifo_count    = CNT_W'(occupancy);
    assign overflow      = overflow_q;
    assign rx_count      = rx_count_q;
    assign tx_count      = tx_count_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: a backpressure instance and a drop-on-full instance share
// stimulus; a queue-level model is compared every cycle, plus hand-computed literal checks.
module tb_uart_echo_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        m_ready;
    logic [1:0]  mode;
    logic        clear;

    logic [1:0]       s_ready;
    logic [1:0][7:0]  m_data;
    logic [1:0]       m_valid;
    logic [1:0][4:0]  fcnt;
    logic [1:0]       ovf;
    logic [1:0][15:0] rxc;
    logic [1:0][15:0] txc;

    int nvec = 0;
    int nerr = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    uart_echo_buffer #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ON_FULL(0), .COUNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready),
        .mode(mode), .clear_status(clear),
        .fifo_count(fcnt[0]), .overflow(ovf[0]), .rx_count(rxc[0]), .tx_count(txc[0])
    );

    uart_echo_buffer #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ON_FULL(1), .COUNT_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready),
        .mode(mode), .clear_status(clear),
        .fifo_count(fcnt[1]), .overflow(ovf[1]), .rx_count(rxc[1]), .tx_count(txc[1])
    );

    // ---------------- behavioural model (list of stored bytes per instance)
    logic [7:0]  mlist [2][DEPTH];
    int          mcnt  [2];
    logic [7:0]  mout  [2];
    bit          mval  [2];
    bit          movf  [2];
    logic [15:0] mrx   [2];
    logic [15:0] mtx   [2];

    function automatic logic [7:0] flip(input logic [7:0] c);
        if (c >= "A" && c <= "Z") return c + 8'd32;
        if (c >= "a" && c <= "z") return c - 8'd32;
        return c;
    endfunction

    function automatic bit exp_ready(input int i);
        return !rst_n || (i == 1) || (mcnt[i] != DEPTH) || (mode == 2'b11);
    endfunction

    always @(posedge clk) begin
        bit was_full, acc, took, can_pop;
        logic [7:0] w;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mcnt[i] = 0; mout[i] = 8'h00; mval[i] = 1'b0;
                movf[i] = 1'b0; mrx[i] = 16'd0; mtx[i] = 16'd0;
            end else begin
                was_full = (mcnt[i] == DEPTH);
                acc      = s_valid && exp_ready(i);
                took     = mval[i] && m_ready;
                can_pop  = (!mval[i] || m_ready) && (mcnt[i] > 0) && (mode < 2'b10);
                if (can_pop) begin
                    w = mlist[i][0];
                    for (int k = 0; k < DEPTH - 1; k++) mlist[i][k] = mlist[i][k+1];
                    mcnt[i] = mcnt[i] - 1;
                    mout[i] = (mode == 2'b01) ? flip(w) : w;
                    mval[i] = 1'b1;
                end else if (took) begin
                    mval[i] = 1'b0;
                end
                if (mode == 2'b11) mcnt[i] = 0;
                if (acc && mode != 2'b11) begin
                    if (!was_full) begin
                        mlist[i][mcnt[i]] = s_data;
                        mcnt[i] = mcnt[i] + 1;
                        mrx[i]  = mrx[i] + 16'd1;
                    end else begin
                        movf[i] = 1'b1;
                    end
                end
                if (took) mtx[i] = mtx[i] + 16'd1;
                if (clear) begin
                    movf[i] = 1'b0; mrx[i] = 16'd0; mtx[i] = 16'd0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[dut%0d] @%0t: got %0h, expected %0h", nm, idx, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled at the falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk("s_axis_tready", i, 32'(s_ready[i]), 32'(exp_ready(i)));
                chk("m_axis_tvalid", i, 32'(m_valid[i]), 32'(mval[i]));
                chk("m_axis_tdata",  i, 32'(m_data[i]),  32'(mout[i]));
                chk("fifo_count",    i, 32'(fcnt[i]),    32'(mcnt[i]));
                chk("overflow",      i, 32'(ovf[i]),     32'(movf[i]));
                chk("rx_count",      i, 32'(rxc[i]),     32'(mrx[i]));
                chk("tx_count",      i, 32'(txc[i]),     32'(mtx[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    logic [7:0] vin  [4];
    logic [7:0] vexp [4];

    initial begin
        rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;
        mode = 2'b00; clear = 1'b0;
        step();
        started = 1'b1;
        step();
        chk("reset_tready", 0, 32'(s_ready[0]), 32'd1);
        chk("reset_tvalid", 0, 32'(m_valid[0]), 32'd0);
        chk("reset_count",  1, 32'(fcnt[1]),    32'd0);
        rst_n = 1'b1;
        step();

        // Echo: one word per cycle, each visible one edge after acceptance.
        vin[0] = 8'h31; vin[1] = 8'h32; vin[2] = 8'h33; vin[3] = 8'h34;
        vexp = vin;
        for (int j = 0; j < 5; j++) begin
            s_valid = (j < 3); s_data = (j < 3) ? vin[j] : 8'h00;
            step();
            if (j >= 1 && j <= 3) chk("echo_data", 0, 32'(m_data[0]), 32'(vexp[j-1]));
        end
        step(); step();
        chk("echo_rx",  0, 32'(rxc[0]), 32'd3);
        chk("echo_tx",  1, 32'(txc[1]), 32'd3);
        chk("echo_ovf", 0, 32'(ovf[0]), 32'd0);

        // Case swap.
        mode = 2'b01;
        vin[0] = 8'h61; vin[1] = 8'h5A; vin[2] = 8'h40; vin[3] = 8'h7B;
        vexp[0] = 8'h41; vexp[1] = 8'h7A; vexp[2] = 8'h40; vexp[3] = 8'h7B;
        for (int j = 0; j < 5; j++) begin
            s_valid = (j < 4); s_data = (j < 4) ? vin[j] : 8'h00;
            step();
            if (j >= 1) chk("swap_data", 0, 32'(m_data[0]), 32'(vexp[j-1]));
        end
        step(); step();

        // Hold: fill beyond depth; backpressure on dut0, drop + overflow on dut1.
        pulse_clear();
        mode = 2'b10;
        for (int j = 0; j < 20; j++) begin
            s_valid = 1'b1; s_data = 8'(8'h80 + j);
            step();
        end
        s_valid = 1'b0;
        chk("hold_tready", 0, 32'(s_ready[0]), 32'd0);
        chk("hold_count",  0, 32'(fcnt[0]),    32'd16);
        chk("hold_count",  1, 32'(fcnt[1]),    32'd16);
        chk("hold_ovf",    1, 32'(ovf[1]),     32'd1);
        chk("hold_rx",     1, 32'(rxc[1]),     32'd16);
        chk("hold_tvalid", 0, 32'(m_valid[0]), 32'd0);

        // Clear coinciding with a (dropped) write: clear wins.
        clear = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
        step();
        clear = 1'b0; s_valid = 1'b0;
        chk("clr_ovf",   1, 32'(ovf[1]),  32'd0);
        chk("clr_rx",    1, 32'(rxc[1]),  32'd0);
        chk("clr_count", 1, 32'(fcnt[1]), 32'd16);

        mode = 2'b00;
        for (int j = 0; j < 20; j++) step();
        chk("drain_tready", 0, 32'(s_ready[0]), 32'd1);
        chk("drain_tx",     0, 32'(txc[0]),     32'd16);
        chk("drain_tx",     1, 32'(txc[1]),     32'd16);

        // Flush with a held output word under backpressure.
        pulse_clear();
        m_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            s_valid = 1'b1; s_data = (j == 0) ? 8'h55 : 8'(j);
            step();
        end
        s_valid = 1'b0;
        step();
        chk("flush_pre_count", 0, 32'(fcnt[0]), 32'd5);
        mode = 2'b11;
        step();
        chk("flush_count", 0, 32'(fcnt[0]),    32'd0);
        chk("flush_data",  1, 32'(m_data[1]),  32'h55);
        chk("flush_valid", 1, 32'(m_valid[1]), 32'd1);
        step(); step();
        chk("flush_hold", 0, 32'(m_data[0]), 32'h55);
        m_ready = 1'b1;
        step();
        chk("flush_tx",    0, 32'(txc[0]),     32'd1);
        chk("flush_empty", 0, 32'(m_valid[0]), 32'd0);
        mode = 2'b00;
        step(); step();

        // Reset mid-stream with the FIFO half full.
        mode = 2'b10;
        for (int j = 0; j < 8; j++) begin
            s_valid = 1'b1; s_data = 8'(8'hA0 + j);
            step();
        end
        s_valid = 1'b0;
        chk("pre_rst_count", 0, 32'(fcnt[0]), 32'd8);
        rst_n = 1'b0;
        step();
        chk("rst_count", 0, 32'(fcnt[0]),    32'd0);
        chk("rst_data",  0, 32'(m_data[0]),  32'd0);
        chk("rst_valid", 1, 32'(m_valid[1]), 32'd0);
        chk("rst_rx",    1, 32'(rxc[1]),     32'd0);
        rst_n = 1'b1; mode = 2'b00;
        s_valid = 1'b1; s_data = 8'h5A;
        step();
        s_valid = 1'b0;
        step();
        chk("post_rst_data",  0, 32'(m_data[0]),  32'h5A);
        chk("post_rst_valid", 0, 32'(m_valid[0]), 32'd1);
        step(); step();

        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
